axis_filter_sched: RTL and testbench

- Frame-aware scheduler that drives the `button` input of an AXI-stream filter/valve stage: [1] pass, [0] filter.
- Runs a programmed pass/drop schedule: pass N frames, drop M frames, optionally repeated.
- Toggles `button` only on frame boundaries, so a frame is never partially passed.
- Watches the filter's upstream handshake (`tvalid`/`tready`/`tlast`) to find frame ends; sits beside the filter in the datapath.

---
 rtl/axis_filter_sched.sv | 185 ++++++++++++++++++
 tb/tb_axis_filter_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_filter_sched.sv
// Frame-aware pass/drop scheduler for an AXI-stream filter's button input.
// Runs a programmed schedule (pass N frames, drop M frames, optionally looped)
// and only ever moves the button on frame boundaries seen on the upstream
// handshake it monitors.
//
// Ports:
//   aclk, rst                       clock, synchronous active-high reset
//   cfg_start, cfg_abort            one-cycle control pulses
//   cfg_pass_frames/drop_frames     frames per phase, latched on accepted start
//   cfg_repeat                      1 = loop until abort, 0 = run once
//   mon_tvalid/tready/tlast         observed upstream handshake (never driven)
//   button                          registered: 1 = pass, 0 = filter
//   busy, phase_pass                status: not IDLE / in PASS
//   frame_cnt                       frames completed in the current phase
//   done                            one-cycle pulse when a schedule completes
module axis_filter_sched #(
  parameter int unsigned CNT_W       = 16,
  parameter bit          IDLE_BUTTON = 1'b0
) (
  input  logic             aclk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic [CNT_W-1:0] cfg_pass_frames,
  input  logic [CNT_W-1:0] cfg_drop_frames,
  input  logic             cfg_repeat,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             button,
  output logic             busy,
  output logic             phase_pass,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StArm, StPass, StDrop, StAbort} state_e;

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pass_n_q, drop_n_q;
  logic             rep_q;
  logic             in_frame_q, in_frame_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             button_q, button_d;
  logic             done_q, done_d;

  logic beat, frame_end, boundary, start_ok;
  state_e first_st, eoc_st;
  logic   first_done, eoc_done;

  assign beat      = mon_tvalid & mon_tready;
  assign frame_end = beat & mon_tlast;
  // Safe switch point: either a frame just ended, or we are between frames and
  // no beat is opening a new one in this cycle.
  assign boundary  = frame_end | (~in_frame_q & ~beat);
  assign start_ok  = cfg_start & ~cfg_abort;

  always_comb begin
    in_frame_d = in_frame_q;
    if (frame_end)  in_frame_d = 1'b0;
    else if (beat)  in_frame_d = 1'b1;
  end

  // First phase of a schedule cycle; also the restart point when looping.
  always_comb begin
    first_st   = StIdle;
    first_done = 1'b0;
    if (pass_n_q != '0)      first_st = StPass;
    else if (drop_n_q != '0) first_st = StDrop;
    else                     first_done = 1'b1;
    eoc_st   = StIdle;
    eoc_done = 1'b1;
    if (rep_q) begin
      eoc_st   = first_st;
      eoc_done = first_done;
    end
  end

  // State register
  always_ff @(posedge aclk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      StIdle: begin
        frame_cnt_d = '0;
        if (start_ok) state_d = StArm;
      end
      StArm: begin
        if (cfg_abort) begin
          state_d = StAbort;
        end else if (boundary) begin
          state_d = first_st;
          done_d  = first_done;
        end
      end
      StPass: begin
        if (cfg_abort) begin
          state_d = StAbort;
        end else if (frame_end) begin
          if (frame_cnt_q == pass_n_q - One) begin
            frame_cnt_d = '0;
            if (drop_n_q != '0) begin
              state_d = StDrop;
            end else begin
              state_d = eoc_st;
              done_d  = eoc_done;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + One;
          end
        end
      end
      StDrop: begin
        if (cfg_abort) begin
          state_d = StAbort;
        end else if (frame_end) begin
          if (frame_cnt_q == drop_n_q - One) begin
            frame_cnt_d = '0;
            state_d     = eoc_st;
            done_d      = eoc_done;
          end else begin
            frame_cnt_d = frame_cnt_q + One;
          end
        end
      end
      StAbort: begin
        if (boundary) begin
          state_d     = StIdle;
          frame_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: button is registered from the next state so it changes the
  // cycle after the qualifying frame-end beat.
  always_comb begin
    button_d = button_q;
    case (state_d)
      StIdle, StArm: button_d = IDLE_BUTTON;
      StPass:        button_d = 1'b1;
      StDrop:        button_d = 1'b0;
      default:       button_d = button_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      pass_n_q    <= '0;
      drop_n_q    <= '0;
      rep_q       <= 1'b0;
      in_frame_q  <= 1'b0;
      frame_cnt_q <= '0;
      button_q    <= IDLE_BUTTON;
      done_q      <= 1'b0;
    end else begin
      if (state_q == StIdle && start_ok) begin
        pass_n_q <= cfg_pass_frames;
        drop_n_q <= cfg_drop_frames;
        rep_q    <= cfg_repeat;
      end
      in_frame_q  <= in_frame_d;
      frame_cnt_q <= frame_cnt_d;
      button_q    <= button_d;
      done_q      <= done_d;
    end
  end

  assign button     = button_q;
  assign busy       = (state_q != StIdle);
  assign phase_pass = (state_q == StPass);
  assign frame_cnt  = frame_cnt_q;
  assign done       = done_q;

endmodule

// File: tb/tb_axis_filter_sched.sv
module tb_axis_filter_sched;

  localparam int unsigned CNT_W = 16;

  logic             aclk = 1'b0;
  logic             rst;
  logic             cfg_start, cfg_abort, cfg_repeat;
  logic [CNT_W-1:0] cfg_pass_frames, cfg_drop_frames;
  logic             mon_tvalid, mon_tready, mon_tlast;
  logic             button, busy, phase_pass, done;
  logic [CNT_W-1:0] frame_cnt;

  axis_filter_sched #(.CNT_W(CNT_W), .IDLE_BUTTON(1'b0)) dut (
    .aclk            (aclk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_abort       (cfg_abort),
    .cfg_pass_frames (cfg_pass_frames),
    .cfg_drop_frames (cfg_drop_frames),
    .cfg_repeat      (cfg_repeat),
    .mon_tvalid      (mon_tvalid),
    .mon_tready      (mon_tready),
    .mon_tlast       (mon_tlast),
    .button          (button),
    .busy            (busy),
    .phase_pass      (phase_pass),
    .frame_cnt       (frame_cnt),
    .done            (done)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic btn;
    logic bsy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted beat is compared against the next queued expectation.
  always @(negedge aclk) begin
    if (!rst && done) done_seen++;
    if (!rst && mon_tvalid && mon_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got beat with button=%0d, expected no beat", button);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("beat_button", int'(button), int'(e.btn));
        chk("beat_busy", int'(busy), int'(e.bsy));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
  endtask

  task automatic idle(input int n);
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic beat(input logic last, input logic btn, input logic bsy);
    exp_t e;
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = last;
    e.btn = btn;
    e.bsy = bsy;
    exp_q.push_back(e);
    tick();
  endtask

  task automatic start(input int p, input int d, input logic r);
    cfg_pass_frames = CNT_W'(p);
    cfg_drop_frames = CNT_W'(d);
    cfg_repeat      = r;
    cfg_start       = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0; cfg_abort = 1'b0; cfg_repeat = 1'b0;
    cfg_pass_frames = '0; cfg_drop_frames = '0;
    mon_tvalid = 1'b0; mon_tready = 1'b1; mon_tlast = 1'b0;
    idle(3);
    chk("rst_button", int'(button), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_phase", int'(phase_pass), 0);
    chk("rst_cnt", int'(frame_cnt), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    idle(1);

    // pass 2, drop 1, once
    start(2, 1, 1'b0);
    idle(2);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    idle(1);
    chk("t1_done_cnt", done_seen, 1);

    // start lands mid-frame: PASS waits for that frame's tlast
    beat(1'b0, 1'b0, 1'b0);
    start(1, 0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    idle(1);
    chk("t2_done_cnt", done_seen, 2);

    // pass 1, drop 2, repeat: P,D,D x3
    start(1, 2, 1'b1);
    idle(2);
    for (int i = 0; i < 9; i++) beat(1'b1, (i % 3) == 0, 1'b1);
    idle(1);
    chk("t3_phase", int'(phase_pass), 1);
    chk("t3_done_cnt", done_seen, 2);
    cfg_abort = 1'b1;
    idle(1);
    chk("t3_abort_hold", int'(button), 1);
    chk("t3_abort_busy", int'(busy), 1);
    idle(1);
    chk("t3_idle_button", int'(button), 0);
    chk("t3_idle_busy", int'(busy), 0);

    // abort on beat 2 of a 4-beat passing frame
    start(5, 0, 1'b0);
    idle(2);
    beat(1'b0, 1'b1, 1'b1);
    cfg_abort = 1'b1;
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b0, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    idle(1);
    chk("t4_done_cnt", done_seen, 2);
    chk("t4_cnt", int'(frame_cnt), 0);

    // empty schedule
    start(0, 0, 1'b0);
    idle(1);
    chk("t5_arm_busy", int'(busy), 1);
    idle(1);
    chk("t5_done", int'(done), 1);
    chk("t5_busy", int'(busy), 0);
    beat(1'b1, 1'b0, 1'b0);
    chk("t5_done_cnt", done_seen, 3);

    // drop-only schedule
    start(0, 3, 1'b0);
    idle(2);
    chk("t5b_phase", int'(phase_pass), 0);
    chk("t5b_busy", int'(busy), 1);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    chk("t5b_cnt", int'(frame_cnt), 2);
    beat(1'b1, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    idle(1);
    chk("t5b_done_cnt", done_seen, 4);

    // back-to-back PASS->DROP, then reset mid-DROP frame
    start(1, 2, 1'b1);
    idle(2);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b0, 1'b1);
    chk("t6_cnt", int'(frame_cnt), 1);
    beat(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1);
    chk("t6_rst_button", int'(button), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_cnt", int'(frame_cnt), 0);
    rst = 1'b0;
    // in_frame was discarded, so PASS starts without waiting for a tlast
    start(1, 0, 1'b0);
    idle(2);
    chk("t6_pass_after_rst", int'(phase_pass), 1);
    beat(1'b1, 1'b1, 1'b1);
    idle(1);
    chk("t6_done_cnt", done_seen, 5);

    // abort in IDLE, start+abort together, start while busy
    cfg_abort = 1'b1;
    idle(1);
    chk("idle_abort_busy", int'(busy), 0);
    start(1, 0, 1'b0);
    cfg_abort = 1'b1;
    idle(2);
    chk("start_abort_busy", int'(busy), 0);
    start(1, 0, 1'b1);
    idle(2);
    start(0, 0, 1'b0);
    idle(1);
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1);
    cfg_abort = 1'b1;
    idle(2);
    chk("busy_start_busy", int'(busy), 0);
    chk("final_done_cnt", done_seen, 5);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
